// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB pipeline register: default widths and
// the default-width payload layout carried through the stage.
package mem_wb_pkg;

  localparam int MEM_WB_DATA_W = 32;
  localparam int MEM_WB_DEST_W = 4;
  localparam int MEM_WB_CNT_W  = 16;

  typedef struct packed {
    logic                     wb_en;
    logic                     mem_r_en;
    logic [MEM_WB_DATA_W-1:0] alu_result;
    logic [MEM_WB_DATA_W-1:0] mem_read_value;
    logic [MEM_WB_DEST_W-1:0] dest;
  } mem_wb_payload_t;

  localparam int MEM_WB_PAYLOAD_W = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry (main + skid) pipeline buffer with a registered ready, so the
// upstream ready never depends combinationally on the downstream ready.
module pipe_skid_buf
  import mem_wb_pkg::*;
#(
  parameter int WIDTH = MEM_WB_PAYLOAD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             skid_valid
);

  logic             main_vld_p0, skid_vld_p0, in_ready_p0;
  logic [WIDTH-1:0] main_data_p0, skid_data_p0;

  logic             main_vld_n, skid_vld_n;
  logic [WIDTH-1:0] main_data_n, skid_data_n;
  logic             accept, drain;

  assign accept = in_valid && in_ready_p0;
  assign drain  = main_vld_p0 && out_ready;

  always_comb begin
    main_vld_n  = main_vld_p0;
    skid_vld_n  = skid_vld_p0;
    main_data_n = main_data_p0;
    skid_data_n = skid_data_p0;
    if (!main_vld_p0 || drain) begin
      if (skid_vld_p0) begin
        // Older skid beat moves up; any new beat takes the freed skid slot.
        main_vld_n  = 1'b1;
        main_data_n = skid_data_p0;
        skid_vld_n  = accept;
        if (accept) skid_data_n = in_data;
      end else begin
        main_vld_n = accept;
        if (accept) main_data_n = in_data;
      end
    end else if (accept) begin
      skid_vld_n  = 1'b1;
      skid_data_n = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_p0  <= 1'b0;
      skid_vld_p0  <= 1'b0;
      in_ready_p0  <= 1'b1;
      main_data_p0 <= '0;
      skid_data_p0 <= '0;
    end else if (flush) begin
      main_vld_p0 <= 1'b0;
      skid_vld_p0 <= 1'b0;
      in_ready_p0 <= 1'b1;
    end else begin
      main_vld_p0  <= main_vld_n;
      skid_vld_p0  <= skid_vld_n;
      in_ready_p0  <= !skid_vld_n;
      main_data_p0 <= main_data_n;
      skid_data_p0 <= skid_data_n;
    end
  end

  assign in_ready   = in_ready_p0;
  assign out_valid  = main_vld_p0;
  assign out_data   = main_data_p0;
  assign skid_valid = skid_vld_p0;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: skid-buffered payload, writeback mux and stall counter.
// Define MEM_WB_PIPE_FWD_EN to add the fwd_valid/fwd_dest/fwd_value bypass outputs.
module mem_wb_pipe_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = MEM_WB_DATA_W,
  parameter int DEST_W = MEM_WB_DEST_W,
  parameter int CNT_W  = MEM_WB_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_read_value_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_read_value,
  output logic [DEST_W-1:0] dest,
  output logic [DATA_W-1:0] wb_value,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
`ifdef MEM_WB_PIPE_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_value
`endif
);

  // Same field order as mem_wb_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_read_value;
    logic [DEST_W-1:0] dest;
  } payload_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  payload_t        pay_in, pay_out;
  logic            skid_valid;
  logic [CNT_W-1:0] stall_cnt_p0;

  assign pay_in = '{wb_en:          wb_en_in,
                    mem_r_en:       mem_r_en_in,
                    alu_result:     alu_result_in,
                    mem_read_value: mem_read_value_in,
                    dest:           dest_in};

  pipe_skid_buf #(
    .WIDTH($bits(payload_t))
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (pay_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (pay_out),
    .skid_valid (skid_valid)
  );

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_p0 <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

  assign wb_en          = pay_out.wb_en && out_valid;
  assign mem_r_en       = pay_out.mem_r_en;
  assign alu_result     = pay_out.alu_result;
  assign mem_read_value = pay_out.mem_read_value;
  assign dest           = pay_out.dest;
  assign wb_value       = pay_out.mem_r_en ? pay_out.mem_read_value : pay_out.alu_result;
  assign occupancy      = {1'b0, out_valid} + {1'b0, skid_valid};
  assign stall_cnt      = stall_cnt_p0;

`ifdef MEM_WB_PIPE_FWD_EN
  assign fwd_valid = wb_en;
  assign fwd_dest  = pay_out.dest;
  assign fwd_value = wb_value;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: default instance plus a CNT_W=4 instance
// sharing the same stimulus for the saturation case.
module tb_mem_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        wb_en_in, mem_r_en_in;
  logic [31:0] alu_result_in, mem_read_value_in;
  logic [3:0]  dest_in;

  logic        in_ready, out_valid, wb_en, mem_r_en;
  logic [31:0] alu_result, mem_read_value, wb_value;
  logic [3:0]  dest;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        in_ready4, out_valid4, wb_en4, mem_r_en4;
  logic [31:0] alu_result4, mem_read_value4, wb_value4;
  logic [3:0]  dest4;
  logic [1:0]  occupancy4;
  logic [3:0]  stall_cnt4;

`ifdef MEM_WB_PIPE_FWD_EN
  logic        fwd_valid, fwd_valid4;
  logic [3:0]  fwd_dest, fwd_dest4;
  logic [31:0] fwd_value, fwd_value4;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .alu_result_in(alu_result_in),
    .mem_read_value_in(mem_read_value_in), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .alu_result(alu_result), .mem_read_value(mem_read_value), .dest(dest),
    .wb_value(wb_value), .occupancy(occupancy), .stall_cnt(stall_cnt)
`ifdef MEM_WB_PIPE_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value)
`endif
  );

  mem_wb_pipe_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .alu_result_in(alu_result_in),
    .mem_read_value_in(mem_read_value_in), .dest_in(dest_in),
    .out_valid(out_valid4), .out_ready(out_ready), .wb_en(wb_en4), .mem_r_en(mem_r_en4),
    .alu_result(alu_result4), .mem_read_value(mem_read_value4), .dest(dest4),
    .wb_value(wb_value4), .occupancy(occupancy4), .stall_cnt(stall_cnt4)
`ifdef MEM_WB_PIPE_FWD_EN
    , .fwd_valid(fwd_valid4), .fwd_dest(fwd_dest4), .fwd_value(fwd_value4)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic mre,
                       input logic [31:0] alu, input logic [31:0] mrv, input logic [3:0] d);
    in_valid          = v;
    wb_en_in          = we;
    mem_r_en_in       = mre;
    alu_result_in     = alu;
    mem_read_value_in = mrv;
    dest_in           = d;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state, visible without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_wb_en",     64'(wb_en),     64'd0);
    step(); step();
    rst_n = 1'b1;

    // Streaming: 8 beats at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, i[0], 32'(i * 16), 32'h1000 + 32'(i), 4'(i));
      step();
      check("str_out_valid", 64'(out_valid), 64'd1);
      check("str_dest",      64'(dest),      64'(i));
      check("str_wb_value",  64'(wb_value),  i[0] ? 64'(32'h1000 + i) : 64'(i * 16));
      check("str_in_ready",  64'(in_ready),  64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check("str_drained", 64'(out_valid), 64'd0);
    check("str_stall",   64'(stall_cnt), 64'd0);

    // Backpressure: 3 beats offered, 2 held, then drained in order
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 4'd1);
    step();
    check("bp_occ1",   64'(occupancy), 64'd1);
    check("bp_rdy1",   64'(in_ready),  64'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 4'd2);
    step();
    check("bp_occ2",   64'(occupancy), 64'd2);
    check("bp_rdy2",   64'(in_ready),  64'd0);
    check("bp_stall1", 64'(stall_cnt), 64'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h33, 32'h0, 4'd3);
    step();
    check("bp_occ_hold",  64'(occupancy),  64'd2);
    check("bp_dest_hold", 64'(dest),       64'd1);
    check("bp_alu_hold",  64'(alu_result), 64'h11);
    check("bp_stall2",    64'(stall_cnt),  64'd2);
    out_ready = 1'b1;
    step();
    check("bp_dest_a", 64'(dest),      64'd2);
    check("bp_occ_a",  64'(occupancy), 64'd1);
    check("bp_rdy_a",  64'(in_ready),  64'd1);
    step();
    check("bp_dest_b", 64'(dest),      64'd3);
    check("bp_alu_b",  64'(alu_result), 64'h33);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check("bp_empty", 64'(occupancy), 64'd0);
    check("bp_stall", 64'(stall_cnt), 64'd2);

    // Writeback mux
    drive(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'd4);
    step();
    check("mux_mem", 64'(wb_value), 64'hDEADBEEF);
    check("mux_wb_en", 64'(wb_en), 64'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'd4);
    step();
    check("mux_alu", 64'(wb_value), 64'h10);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check("idle_wb_en",   64'(wb_en),      64'd0);
    check("idle_alu_hold", 64'(alu_result), 64'h10);

    // Flush with both entries full and a beat on offer
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 4'd5);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 4'd6);
    step();
    check("fl_occ_pre", 64'(occupancy), 64'd2);
    drive(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 4'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_occ",       64'(occupancy), 64'd0);
    check("fl_in_ready",  64'(in_ready),  64'd1);
    check("fl_wb_en",     64'(wb_en),     64'd0);
    check("fl_stall_kept", 64'(stall_cnt), 64'd4);

    // Asynchronous reset mid-stream
    drive(1'b1, 1'b1, 1'b0, 32'h88, 32'h0, 4'd8);
    step(); step();
    check("ar_occ_pre", 64'(occupancy), 64'd2);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_occ",       64'(occupancy), 64'd0);
    check("ar_in_ready",  64'(in_ready),  64'd1);
    check("ar_stall",     64'(stall_cnt), 64'd0);
    check("ar_dest",      64'(dest),      64'd0);
    step();
    rst_n = 1'b1;

    // Saturation on the 4-bit counter, first accept right after reset
    drive(1'b1, 1'b1, 1'b0, 32'h99, 32'h0, 4'd9);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("sat_first_accept", 64'(out_valid4), 64'd1);
    for (int k = 1; k <= 20; k++) begin
      step();
`ifdef MEM_WB_PIPE_FWD_EN
      check("fwd_valid", 64'(fwd_valid4), 64'd1);
      check("fwd_dest",  64'(fwd_dest4),  64'd9);
`endif
      if (k == 14) check("sat_14", 64'(stall_cnt4), 64'd14);
      if (k == 15) check("sat_15", 64'(stall_cnt4), 64'd15);
    end
    check("sat_20",     64'(stall_cnt4), 64'd15);
    check("sat_wide20", 64'(stall_cnt),  64'd20);
    check("sat_dest",   64'(dest4),      64'd9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
